dmem_arbiter: RTL and testbench

- Two-requester arbiter that shares the single-port data memory between the core load/store path (port 0) and a loader/DMA engine (port 1).
- Sits between both requesters and the data memory. It drives MemWrite, MemRead, address and write data, and returns the memory's combinational read data to the granted port.
- Uses a registered grant state machine, round-robin fairness and valid/ack handshakes.

---
 rtl/dmem_arb_pkg.sv | 18 +
 rtl/dmem_arbiter_rr_pick.sv | 18 +
 rtl/dmem_arbiter.sv | 112 +++++++++++
 tb/tb_dmem_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: state encoding and port indices shared by the data-memory arbiter.
// Revision 1.0
`default_nettype none

package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_e;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DMA  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/dmem_arbiter_rr_pick.sv
// rr_pick2: combinational two-way round-robin picker; rr names the tie winner.
// Revision 1.0
`default_nettype none

module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic rr,
  output logic gnt_valid,
  output logic gnt_idx
);

  assign gnt_valid = req0 | req1;
  assign gnt_idx   = (req0 && req1) ? rr : req1;

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin valid/ack arbiter sharing one data memory between core and DMA.
// Optional conflict counter enabled by DMEM_ARB_STATS_EN. Revision 1.0
`default_nettype none

module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int Width   = 32,
  parameter int STATS_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             we0,
  input  logic [Width-1:0] addr0,
  input  logic [Width-1:0] wdata0,
  output logic             ack0,
  output logic [Width-1:0] rdata0,
  input  logic             req1,
  input  logic             we1,
  input  logic [Width-1:0] addr1,
  input  logic [Width-1:0] wdata1,
  output logic             ack1,
  output logic [Width-1:0] rdata1,
  output logic             MemWrite,
  output logic             MemRead,
  output logic [Width-1:0] MemAddr,
  output logic [Width-1:0] MemWData,
  input  logic [Width-1:0] MemRData
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [STATS_W-1:0] conflict_cnt
`endif
);

  arb_state_e state;
  logic       rr;
  logic       pick_rr;
  logic       gnt_valid;
  logic       gnt_idx;

  // While granted, the other port wins any tie so continuous requests alternate.
  always_comb begin
    pick_rr = rr;
    if (state == GRANT0) pick_rr = PORT_DMA;
    else if (state == GRANT1) pick_rr = PORT_CORE;
  end

  rr_pick2 u_pick (
    .req0      (req0),
    .req1      (req1),
    .rr        (pick_rr),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rr    <= PORT_CORE;
    end else begin
      if (!gnt_valid)  state <= IDLE;
      else if (gnt_idx) state <= GRANT1;
      else             state <= GRANT0;
      if (ack0)      rr <= PORT_DMA;
      else if (ack1) rr <= PORT_CORE;
    end
  end

  always_comb begin
    ack0     = 1'b0;
    ack1     = 1'b0;
    rdata0   = '0;
    rdata1   = '0;
    MemWrite = 1'b0;
    MemRead  = 1'b0;
    MemAddr  = '0;
    MemWData = '0;
    case (state)
      GRANT0: begin
        MemAddr  = addr0;
        MemWData = wdata0;
        MemWrite = req0 && we0;
        MemRead  = req0 && !we0;
        ack0     = req0;
        if (req0 && !we0) rdata0 = MemRData;
      end
      GRANT1: begin
        MemAddr  = addr1;
        MemWData = wdata1;
        MemWrite = req1 && we1;
        MemRead  = req1 && !we1;
        ack1     = req1;
        if (req1 && !we1) rdata1 = MemRData;
      end
      default: ;
    endcase
  end

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
    end else if (req0 && req1 && (ack0 ^ ack1) && (conflict_cnt != '1)) begin
      conflict_cnt <= conflict_cnt + 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter with a small memory model.
`default_nettype none

module tb_dmem_arbiter;

  localparam int W  = 32;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, we0, req1, we1;
  logic [W-1:0]  addr0, wdata0, addr1, wdata1;
  logic          ack0, ack1;
  logic [W-1:0]  rdata0, rdata1;
  logic          MemWrite, MemRead;
  logic [W-1:0]  MemAddr, MemWData, MemRData;
`ifdef DMEM_ARB_STATS_EN
  logic [SW-1:0] conflict_cnt;
`endif

  logic [W-1:0]  mem [16];
  int            tests = 0;
  int            fails = 0;

  always #5 clk = ~clk;

  assign MemRData = mem[MemAddr[3:0]];
  always @(posedge clk) if (MemWrite) mem[MemAddr[3:0]] <= MemWData;

  dmem_arbiter #(.Width(W), .STATS_W(SW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .MemWrite(MemWrite), .MemRead(MemRead), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemRData(MemRData)
`ifdef DMEM_ARB_STATS_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    rst_n = 1'b0;
    step();
    // Outputs must be quiet even with requests pending under reset.
    req0 = 1; we0 = 1; addr0 = 3; req1 = 1; addr1 = 4;
    @(negedge clk);
    tests++;
    if ({ack0, ack1, MemWrite, MemRead} !== 4'b0000) begin
      fails++; $display("FAIL reset_ctrl: got %b expected 0000", {ack0, ack1, MemWrite, MemRead});
    end
    tests++;
    if ({MemAddr, MemWData, rdata0, rdata1} !== '0) begin
      fails++; $display("FAIL reset_data: addr %h wdata %h rd0 %h rd1 %h expected all 0",
                        MemAddr, MemWData, rdata0, rdata1);
    end
    req0 = 0; req1 = 0; we0 = 0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    mem[3] = 32'h0000_0055;
    req0 = 1; we0 = 1; addr0 = 3; wdata0 = 32'hAA;
    step();
    @(negedge clk);
    tests++;
    if ({ack0, MemWrite} !== 2'b11) begin
      fails++; $display("FAIL midrst_grant: ack0/MemWrite got %b expected 11", {ack0, MemWrite});
    end
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if ({ack0, MemWrite} !== 2'b00) begin
      fails++; $display("FAIL midrst_kill: ack0/MemWrite got %b expected 00", {ack0, MemWrite});
    end
    step();
    tests++;
    if (mem[3] !== 32'h55) begin
      fails++; $display("FAIL midrst_mem: mem[3] got %h expected 00000055", mem[3]);
    end
    req0 = 0; we0 = 0;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_store_load();
    do_reset();
    req0 = 1; we0 = 1; addr0 = 5; wdata0 = 32'hDEADBEEF;
    @(negedge clk);
    tests++;
    if (ack0 !== 1'b0) begin
      fails++; $display("FAIL st_idle_ack: ack0 got %b expected 0", ack0);
    end
    step();
    @(negedge clk);
    tests++;
    if ({ack0, MemWrite, MemRead, MemAddr, MemWData} !== {3'b110, 32'd5, 32'hDEADBEEF}) begin
      fails++; $display("FAIL st_ack: ack %b wr %b rd %b addr %h data %h expected 1 1 0 5 deadbeef",
                        ack0, MemWrite, MemRead, MemAddr, MemWData);
    end
    step();
    we0 = 0;
    @(negedge clk);
    tests++;
    if ({ack0, MemRead, MemWrite, rdata0} !== {3'b110, 32'hDEADBEEF}) begin
      fails++; $display("FAIL ld_ack: ack %b rd %b wr %b rdata0 %h expected 1 1 0 deadbeef",
                        ack0, MemRead, MemWrite, rdata0);
    end
    step();
    req0 = 0;
    step();
    step();
  endtask

  task automatic test_simultaneous();
    logic [1:0] exp_seq [4];
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;
    do_reset();
    req0 = 1; we0 = 0; addr0 = 1; req1 = 1; we1 = 0; addr1 = 2;
    mem[1] = 32'h1111; mem[2] = 32'h2222;
    @(negedge clk);
    tests++;
    if ({ack1, ack0} !== 2'b00) begin
      fails++; $display("FAIL sim_idle: acks got %b expected 00", {ack1, ack0});
    end
    for (int i = 0; i < 4; i++) begin
      step();
      @(negedge clk);
      tests++;
      if ({ack1, ack0} !== exp_seq[i]) begin
        fails++; $display("FAIL sim_alt%0d: {ack1,ack0} got %b expected %b", i, {ack1, ack0}, exp_seq[i]);
      end
    end
    tests++;
    if (rdata1 !== 32'h2222 || rdata0 !== 32'h0) begin
      fails++; $display("FAIL sim_rdata: rdata1 %h rdata0 %h expected 2222 0", rdata1, rdata0);
    end
    step();
    req0 = 0; req1 = 0;
    step();
    step();
  endtask

  task automatic test_same_addr();
    do_reset();
    mem[7] = 32'h0;
    req0 = 1; we0 = 1; addr0 = 7; wdata0 = 32'h1;
    req1 = 1; we1 = 1; addr1 = 7; wdata1 = 32'h2;
    step();
    @(negedge clk);
    tests++;
    if ({ack0, ack1, MemWData} !== {2'b10, 32'h1}) begin
      fails++; $display("FAIL race_first: ack0 %b ack1 %b wdata %h expected 1 0 1", ack0, ack1, MemWData);
    end
    step();
    req0 = 0;
    @(negedge clk);
    tests++;
    if ({ack1, MemWData} !== {1'b1, 32'h2}) begin
      fails++; $display("FAIL race_second: ack1 %b wdata %h expected 1 2", ack1, MemWData);
    end
    step();
    req1 = 0;
    step();
    step();
    tests++;
    if (mem[7] !== 32'h2) begin
      fails++; $display("FAIL race_mem: mem[7] got %h expected 2", mem[7]);
    end
    req0 = 1; we0 = 0; addr0 = 7;
    step();
    @(negedge clk);
    tests++;
    if ({ack0, rdata0} !== {1'b1, 32'h2}) begin
      fails++; $display("FAIL race_load: ack0 %b rdata0 %h expected 1 2", ack0, rdata0);
    end
    step();
    req0 = 0;
    step();
    step();
  endtask

  task automatic test_drop();
    do_reset();
    req1 = 1; we1 = 0; addr1 = 3;
    step();
    req1 = 0;
    @(negedge clk);
    tests++;
    if ({ack1, MemRead, MemWrite, rdata1} !== {3'b000, 32'h0}) begin
      fails++; $display("FAIL drop_dead: ack1 %b rd %b wr %b rdata1 %h expected 0 0 0 0",
                        ack1, MemRead, MemWrite, rdata1);
    end
    tests++;
    if (MemAddr !== 32'd3) begin
      fails++; $display("FAIL drop_addr: MemAddr got %h expected 3", MemAddr);
    end
    step();
    @(negedge clk);
    tests++;
    if (MemAddr !== 32'd0) begin
      fails++; $display("FAIL drop_idle: MemAddr got %h expected 0", MemAddr);
    end
    step();
  endtask

`ifdef DMEM_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    req0 = 1; we0 = 0; addr0 = 1; req1 = 1; we1 = 0; addr1 = 2;
    repeat (10) step();
    tests++;
    if (conflict_cnt !== 4'd9) begin
      fails++; $display("FAIL stats_count: conflict_cnt got %0d expected 9", conflict_cnt);
    end
    repeat (10) step();
    tests++;
    if (conflict_cnt !== 4'hF) begin
      fails++; $display("FAIL stats_sat: conflict_cnt got %0d expected 15", conflict_cnt);
    end
    req0 = 0; req1 = 0;
    step();
    step();
  endtask
`endif

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    test_reset();
    test_reset_mid_grant();
    test_store_load();
    test_simultaneous();
    test_same_addr();
    test_drop();
`ifdef DMEM_ARB_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
